// File: rtl/hazard_scoreboard.sv
// Tracks destination, write-back enable and load flag of instructions in EX/MEM/WB
// and raises a stall when an ID source cannot be satisfied by forwarding.
module hazard_scoreboard #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              forward_en,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_src1,
   input  logic [REG_AW-1:0] id_src2,
   input  logic              id_src2_used,
   input  logic [REG_AW-1:0] id_st_src,
   input  logic              id_is_store,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_wb_en,
   input  logic              id_mem_r_en,
   input  logic              cnt_clr,
   output logic              hazard,
   output logic [REG_AW-1:0] ex_dest,
   output logic              ex_wb_en,
   output logic [REG_AW-1:0] mem_dest,
   output logic              mem_wb_en,
   output logic [REG_AW-1:0] wb_dest,
   output logic              wb_wb_en,
   output logic [CNT_W-1:0]  stall_count
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] dest;
      logic              wb_en;
      logic              load;
   } stage_t;

   stage_t ex_q, mem_q, wb_q;
   stage_t ex_next;

   logic hz_src1, hz_src2, hz_st;

   // Register 0 is hard-wired, so it never creates a dependence.
   function automatic logic src_hazard(input logic [REG_AW-1:0] src,
                                       input stage_t ex_s,
                                       input stage_t mem_s,
                                       input logic fwd);
      logic m_ex;
      logic m_mem;
      m_ex  = ex_s.valid  & ex_s.wb_en  & (ex_s.dest  == src) & (src != '0);
      m_mem = mem_s.valid & mem_s.wb_en & (mem_s.dest == src) & (src != '0);
      return fwd ? (m_ex & ex_s.load) : (m_ex | m_mem);
   endfunction

   always_comb begin
      hz_src1 = src_hazard(id_src1,   ex_q, mem_q, forward_en);
      hz_src2 = src_hazard(id_src2,   ex_q, mem_q, forward_en) & id_src2_used;
      hz_st   = src_hazard(id_st_src, ex_q, mem_q, forward_en) & id_is_store;
      hazard  = id_valid & ~flush & (hz_src1 | hz_src2 | hz_st);
   end

   // A killed or stalled ID instruction becomes a bubble in EX.
   always_comb begin
      ex_next = '0;
      if (id_valid && !flush && !hazard) begin
         ex_next.valid = 1'b1;
         ex_next.dest  = id_dest;
         ex_next.wb_en = id_wb_en;
         ex_next.load  = id_mem_r_en;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (!freeze) begin
         ex_q  <= ex_next;
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_count <= '0;
      end else if (!freeze) begin
         if (cnt_clr) begin
            stall_count <= '0;
         end else if (hazard && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
         end
      end
   end

   assign ex_dest   = ex_q.dest;
   assign ex_wb_en  = ex_q.valid & ex_q.wb_en;
   assign mem_dest  = mem_q.dest;
   assign mem_wb_en = mem_q.valid & mem_q.wb_en;
   assign wb_dest   = wb_q.dest;
   assign wb_wb_en  = wb_q.valid & wb_q.wb_en;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one default-width instance plus a
// 4-bit-counter instance sharing the same stimulus for saturation checks.
module tb_hazard_scoreboard;

   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          freeze, flush, forward_en, id_valid;
   logic [AW-1:0] id_src1, id_src2, id_st_src, id_dest;
   logic          id_src2_used, id_is_store, id_wb_en, id_mem_r_en, cnt_clr;

   logic          hazard, ex_wb_en, mem_wb_en, wb_wb_en;
   logic [AW-1:0] ex_dest, mem_dest, wb_dest;
   logic [15:0]   stall_count;

   logic          s_hazard, s_ex_wb_en, s_mem_wb_en, s_wb_wb_en;
   logic [AW-1:0] s_ex_dest, s_mem_dest, s_wb_dest;
   logic [3:0]    s_stall_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hazard_scoreboard u_dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .forward_en(forward_en),
      .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_src2_used(id_src2_used),
      .id_st_src(id_st_src), .id_is_store(id_is_store), .id_dest(id_dest), .id_wb_en(id_wb_en),
      .id_mem_r_en(id_mem_r_en), .cnt_clr(cnt_clr), .hazard(hazard), .ex_dest(ex_dest),
      .ex_wb_en(ex_wb_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .wb_dest(wb_dest),
      .wb_wb_en(wb_wb_en), .stall_count(stall_count)
   );

   hazard_scoreboard #(.REG_AW(AW), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .forward_en(forward_en),
      .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_src2_used(id_src2_used),
      .id_st_src(id_st_src), .id_is_store(id_is_store), .id_dest(id_dest), .id_wb_en(id_wb_en),
      .id_mem_r_en(id_mem_r_en), .cnt_clr(cnt_clr), .hazard(s_hazard), .ex_dest(s_ex_dest),
      .ex_wb_en(s_ex_wb_en), .mem_dest(s_mem_dest), .mem_wb_en(s_mem_wb_en), .wb_dest(s_wb_dest),
      .wb_wb_en(s_wb_wb_en), .stall_count(s_stall_count)
   );

   // Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle();
      freeze = 0; flush = 0; cnt_clr = 0; id_valid = 0;
      id_src1 = '0; id_src2 = '0; id_src2_used = 0; id_st_src = '0;
      id_is_store = 0; id_dest = '0; id_wb_en = 0; id_mem_r_en = 0;
   endtask

   task automatic issue(input logic [AW-1:0] src1, input logic [AW-1:0] src2,
                        input logic src2_used, input logic [AW-1:0] st_src,
                        input logic is_store, input logic [AW-1:0] dest,
                        input logic wb, input logic ld);
      id_valid = 1; id_src1 = src1; id_src2 = src2; id_src2_used = src2_used;
      id_st_src = st_src; id_is_store = is_store; id_dest = dest;
      id_wb_en = wb; id_mem_r_en = ld;
   endtask

   task automatic do_reset();
      idle();
      rst = 0;
      #2;
      rst = 1;
   endtask

   task automatic test_reset();
      rst = 0;
      freeze = 1'($urandom); flush = 1'($urandom); cnt_clr = 1'($urandom);
      forward_en = 1'($urandom); id_valid = 1; id_src1 = 5'($urandom);
      id_src2 = 5'($urandom); id_src2_used = 1'($urandom); id_st_src = 5'($urandom);
      id_is_store = 1'($urandom); id_dest = 5'($urandom); id_wb_en = 1'($urandom);
      id_mem_r_en = 1'($urandom);
      tick(); tick();
      n_tests++;
      if ({hazard, ex_dest, ex_wb_en, mem_dest, mem_wb_en, wb_dest, wb_wb_en} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got haz=%0b ex=%0d/%0b mem=%0d/%0b wb=%0d/%0b expected all 0",
                  hazard, ex_dest, ex_wb_en, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
      end
      n_tests++;
      if (stall_count !== 16'd0 || s_stall_count !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d/%0d expected 0/0", stall_count, s_stall_count);
      end
      idle();
      forward_en = 1;
      rst = 1;
      issue(0, 0, 0, 0, 0, 5, 1, 1);
      tick();
      idle();
      sample();
      n_tests++;
      if (ex_dest !== 5'd5 || ex_wb_en !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_issue: got ex_dest=%0d ex_wb_en=%0b expected 5/1", ex_dest, ex_wb_en);
      end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      forward_en = 1;
      issue(0, 0, 0, 0, 0, 5, 1, 1);
      tick();
      issue(5, 0, 0, 0, 0, 6, 1, 0);
      sample();
      n_tests++;
      if (hazard !== 1'b1) begin
         n_fail++;
         $display("FAIL load_use_hazard: got %0b expected 1", hazard);
      end
      tick();
      sample();
      n_tests++;
      if (hazard !== 1'b0 || ex_wb_en !== 1'b0 || mem_dest !== 5'd5 || mem_wb_en !== 1'b1) begin
         n_fail++;
         $display("FAIL load_use_bubble: got haz=%0b ex_wb_en=%0b mem=%0d/%0b expected 0/0/5/1",
                  hazard, ex_wb_en, mem_dest, mem_wb_en);
      end
      n_tests++;
      if (stall_count !== 16'd1) begin
         n_fail++;
         $display("FAIL load_use_count: got %0d expected 1", stall_count);
      end
      tick();
      idle();
      sample();
      n_tests++;
      if (ex_dest !== 5'd6 || ex_wb_en !== 1'b1) begin
         n_fail++;
         $display("FAIL load_use_issue: got ex=%0d/%0b expected 6/1", ex_dest, ex_wb_en);
      end
   endtask

   task automatic test_alu_dep();
      do_reset();
      forward_en = 1;
      issue(0, 0, 0, 0, 0, 7, 1, 0);
      tick();
      issue(0, 7, 1, 0, 0, 8, 1, 0);
      sample();
      n_tests++;
      if (hazard !== 1'b0) begin
         n_fail++;
         $display("FAIL alu_fwd_no_hazard: got %0b expected 0", hazard);
      end
      do_reset();
      forward_en = 0;
      issue(0, 0, 0, 0, 0, 7, 1, 0);
      tick();
      issue(0, 7, 1, 0, 0, 8, 1, 0);
      sample();
      n_tests++;
      if (hazard !== 1'b1) begin
         n_fail++;
         $display("FAIL alu_nofwd_ex: got %0b expected 1", hazard);
      end
      tick();
      sample();
      n_tests++;
      if (hazard !== 1'b1) begin
         n_fail++;
         $display("FAIL alu_nofwd_mem: got %0b expected 1", hazard);
      end
      tick();
      sample();
      n_tests++;
      if (hazard !== 1'b0 || stall_count !== 16'd2) begin
         n_fail++;
         $display("FAIL alu_nofwd_release: got haz=%0b count=%0d expected 0/2", hazard, stall_count);
      end
      idle();
   endtask

   task automatic test_gating();
      do_reset();
      forward_en = 0;
      issue(0, 0, 0, 0, 0, 7, 1, 0);
      tick();
      issue(3, 7, 0, 0, 0, 8, 1, 0);
      sample();
      n_tests++;
      if (hazard !== 1'b0) begin
         n_fail++;
         $display("FAIL gate_src2_unused: got %0b expected 0", hazard);
      end
      do_reset();
      forward_en = 1;
      issue(0, 0, 0, 0, 0, 5, 1, 1);
      tick();
      issue(0, 0, 0, 5, 1, 0, 0, 0);
      sample();
      n_tests++;
      if (hazard !== 1'b1) begin
         n_fail++;
         $display("FAIL gate_store_src: got %0b expected 1", hazard);
      end
      id_is_store = 0;
      #1;
      n_tests++;
      if (hazard !== 1'b0) begin
         n_fail++;
         $display("FAIL gate_non_store: got %0b expected 0", hazard);
      end
      do_reset();
      forward_en = 0;
      issue(0, 0, 0, 0, 0, 0, 1, 1);
      tick();
      issue(0, 0, 1, 0, 1, 4, 1, 0);
      sample();
      n_tests++;
      if (hazard !== 1'b0) begin
         n_fail++;
         $display("FAIL gate_reg0: got %0b expected 0", hazard);
      end
      idle();
   endtask

   task automatic test_freeze();
      do_reset();
      forward_en = 1;
      issue(0, 0, 0, 0, 0, 5, 1, 1);
      tick();
      issue(5, 0, 0, 0, 0, 6, 1, 0);
      freeze = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         sample();
         n_tests++;
         if (hazard !== 1'b1 || ex_dest !== 5'd5 || ex_wb_en !== 1'b1 ||
             mem_wb_en !== 1'b0 || stall_count !== 16'd0) begin
            n_fail++;
            $display("FAIL freeze_hold[%0d]: got haz=%0b ex=%0d/%0b mem_wb_en=%0b count=%0d expected 1/5/1/0/0",
                     i, hazard, ex_dest, ex_wb_en, mem_wb_en, stall_count);
         end
      end
      tick();
      freeze = 0;
      tick();
      sample();
      n_tests++;
      if (hazard !== 1'b0 || stall_count !== 16'd1 || mem_dest !== 5'd5) begin
         n_fail++;
         $display("FAIL freeze_release: got haz=%0b count=%0d mem=%0d expected 0/1/5",
                  hazard, stall_count, mem_dest);
      end
      idle();
   endtask

   task automatic test_flush();
      do_reset();
      forward_en = 1;
      issue(0, 0, 0, 0, 0, 5, 1, 1);
      tick();
      issue(5, 0, 0, 0, 0, 6, 1, 0);
      flush = 1;
      sample();
      n_tests++;
      if (hazard !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_hazard: got %0b expected 0", hazard);
      end
      tick();
      idle();
      sample();
      n_tests++;
      if (ex_wb_en !== 1'b0 || mem_dest !== 5'd5 || stall_count !== 16'd0) begin
         n_fail++;
         $display("FAIL flush_bubble: got ex_wb_en=%0b mem=%0d count=%0d expected 0/5/0",
                  ex_wb_en, mem_dest, stall_count);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      forward_en = 1;
      issue(0, 0, 0, 0, 0, 5, 1, 1);
      tick();
      issue(5, 0, 0, 0, 0, 6, 1, 0);
      rst = 0;
      #2;
      n_tests++;
      if (hazard !== 1'b0 || ex_wb_en !== 1'b0 || stall_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got haz=%0b ex_wb_en=%0b count=%0d expected 0/0/0",
                  hazard, ex_wb_en, stall_count);
      end
      rst = 1;
      idle();
      tick();
   endtask

   // Ten producer/consumer pairs without forwarding: two stall cycles each.
   task automatic test_saturation();
      do_reset();
      forward_en = 0;
      for (int i = 0; i < 10; i++) begin
         issue(0, 0, 0, 0, 0, 5, 1, 0);
         tick();
         issue(5, 0, 0, 0, 0, 9, 1, 0);
         tick(); tick(); tick();
      end
      idle();
      sample();
      n_tests++;
      if (s_stall_count !== 4'd15) begin
         n_fail++;
         $display("FAIL sat_small: got %0d expected 15", s_stall_count);
      end
      n_tests++;
      if (stall_count !== 16'd20) begin
         n_fail++;
         $display("FAIL sat_wide: got %0d expected 20", stall_count);
      end
      tick();
      cnt_clr = 1;
      tick();
      cnt_clr = 0;
      sample();
      n_tests++;
      if (s_stall_count !== 4'd0 || stall_count !== 16'd0) begin
         n_fail++;
         $display("FAIL cnt_clr: got %0d/%0d expected 0/0", s_stall_count, stall_count);
      end
   endtask

   initial begin
      idle();
      forward_en = 0;
      rst = 0;
      tick();
      test_reset();
      test_load_use();
      test_alu_dep();
      test_gating();
      test_freeze();
      test_flush();
      test_reset_mid();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
